genbcd: RTL and testbench
=========================

Name: genbcd

Overview:
Reverse-direction companion to the binary-entry trainer. The player sees a binary target on LEDR[7:0] and enters its decimal value as three BCD digits on the switches, then submits with KEY3. The block tracks hits and misses, advances the target through an on-chip LFSR, and ends the game on a win or on too many strikes. It is a top-level board game block on the 50 MHz board clock.

Parameters:
- SEED, 8'hB5, initial LFSR value and first target. Must be non-zero.
- ROUNDS, 20, number of correct answers that wins the game (range 1..99).
- MAX_STRIKES, 3, number of wrong submits that ends the game (range 1..15).
- FLASH_CYCLES, 25_000_000, length of the hit/miss feedback hold in clk50 cycles (must be >= 1).

Ports:
- clk50  in  1  board clock, 50 MHz.
- KEY2  in  1  reset; asynchronous, active-low.
- KEY3  in  1  submit pushbutton; raw, active-low, asynchronous to clk50.
- SW  in  18  SW[3:0] ones digit, SW[7:4] tens digit, SW[11:8] hundreds digit; SW[17:12] unused.
- LEDR  out  8  current binary target.
- LEDG  out  8  status: [0] hit, [1] invalid entry, [2] miss, [3] too low, [4] too high, [6] win, [7] game over.
- HEX0/HEX1/HEX2  out  7 each  entered ones/tens/hundreds digits, via hex_display.
- HEX6/HEX7  out  7 each  score ones/tens digits (BCD), via hex_display.
- reset  out  1  equal to !KEY2.

Behaviour:
- Reset (KEY2 low, takes effect immediately):
  - state = S_PLAY, lfsr = SEED, LEDR = SEED.
  - Score = 00, strikes = 0, flash counter = 0, LEDG = 0.
  - Submit synchroniser flops = 1.
- Submit detect:
  - KEY3 passes through a two-flop synchroniser plus an edge register.
  - submit_p is a one-cycle pulse on a synchronised 1->0 transition.
  - Latency is 3 clk50 edges from the pin falling to submit_p.
  - Holding the button produces exactly one pulse.
- Entry:
  - value = hund*100 + tens*10 + ones, computed as a 10-bit unsigned.
  - invalid = any digit > 9. LEDG[1] = invalid, combinational, in every state.
  - HEX0..2 decode SW directly (combinational, no latency).
  - correct = !invalid && value == {2'b0, lfsr}. Values 256..999 are always wrong.
- LFSR next value: {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. It never reaches 0. It steps only on a hit.
- States:
  - S_PLAY:
    - submit_p with correct: lfsr steps, score increments, flash counter loads FLASH_CYCLES-1, go to S_HIT.
    - submit_p without correct: strikes increments, flash counter loads FLASH_CYCLES-1, go to S_MISS.
  - S_HIT:
    - LEDG[0] = 1.
    - Counter decrements each cycle. At 0: go to S_OVER if score == ROUNDS, else S_PLAY.
  - S_MISS:
    - LEDG[2] = 1.
    - At counter 0: go to S_OVER if strikes == MAX_STRIKES, else S_PLAY.
  - S_OVER:
    - LEDG[7] = 1. LEDG[6] = (score == ROUNDS).
    - Absorbing; only reset leaves it.
- Each hit/miss flash lasts exactly FLASH_CYCLES cycles.
- submit_p during S_HIT, S_MISS or S_OVER is ignored (not queued).
- Score:
  - Two BCD nibbles; ones wraps 9->0 with a carry into tens.
  - Saturates at 99.
  - Shown on HEX6 (ones) and HEX7 (tens).
- LEDR updates the cycle after the hit is registered, so the new target is visible during the S_HIT flash.

Optional Feature:
- Macro: GENBCD_HINT_EN.
- When defined:
  - On a valid wrong submit, register the hint: LEDG[3] = (value < target), LEDG[4] = (value > target).
  - The hint holds through S_MISS and is cleared on the S_MISS->S_PLAY transition.
  - An invalid entry sets neither bit.
- When undefined: LEDG[4:3] are tied to 0 and no hint logic exists.

Decomposition:
- Package genbcd_pkg holds:
  - the state enum (S_PLAY, S_HIT, S_MISS, S_OVER);
  - LEDG bit-index constants;
  - the LFSR tap function.
- One natural sub-module: bcd3_to_bin, purely combinational. It takes 3×4-bit BCD and outputs a 10-bit value plus an invalid flag.
- Reuse the existing hex_display for all five HEX outputs.

Test Plan:
- Reset, then release; SW = 0x181, KEY3 pulsed (FLASH_CYCLES=4) -> submit_p 3 cycles after the fall; LEDG[0] high exactly 4 cycles; LEDR = 8'h6B (107); HEX6 = 1, HEX7 = 0.
- SW = 0x180 submitted on target 181 -> LEDG[2] for 4 cycles; strikes = 1; LEDR stays 181; score unchanged. With HINT_EN, LEDG[3] = 1 and LEDG[4] = 0.
- SW = 0x1A1 (tens = A) -> LEDG[1] = 1 immediately; submitting counts as a miss; with HINT_EN, LEDG[4:3] = 0.
- Three wrong submits with MAX_STRIKES = 3 -> after the third flash, LEDG[7] = 1 and LEDG[6] = 0; further KEY3 presses change nothing.
- ROUNDS = 2, two correct submits (181, then 107) -> S_OVER with LEDG[7:6] = 2'b11 and score 02. A KEY3 held low for 100 cycles yields a single pulse.
- KEY2 asserted mid-S_HIT flash -> all outputs return to reset values asynchronously: LEDR = 181, LEDG = 0, score 00.

Source files
------------

// File: rtl/genbcd_pkg.sv
// -----------------------------------------------------------------------------
// genbcd_pkg
// Shared definitions for the genbcd decimal-entry trainer:
//   state_t        - game FSM states
//   LEDG_*         - bit positions of the status LEDs
//   lfsr_next()    - one step of the 8-bit target LFSR
// -----------------------------------------------------------------------------
package genbcd_pkg;

    typedef enum logic [1:0] {
        S_PLAY = 2'd0,
        S_HIT  = 2'd1,
        S_MISS = 2'd2,
        S_OVER = 2'd3
    } state_t;

    localparam int LEDG_HIT     = 0;
    localparam int LEDG_INVALID = 1;
    localparam int LEDG_MISS    = 2;
    localparam int LEDG_LOW     = 3;
    localparam int LEDG_HIGH    = 4;
    localparam int LEDG_WIN     = 6;
    localparam int LEDG_OVER    = 7;

    // Maximal-length taps (8,6,5,4): a non-zero seed never reaches zero.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

endpackage

// File: rtl/bcd3_to_bin.sv
// -----------------------------------------------------------------------------
// bcd3_to_bin
// Purely combinational conversion of three BCD digits to a 10-bit binary value.
// Ports:
//   hund, tens, ones : 4-bit digits
//   value            : hund*100 + tens*10 + ones (only meaningful when valid)
//   invalid          : any digit above 9
// -----------------------------------------------------------------------------
module bcd3_to_bin (
    input  logic [3:0] hund,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [9:0] value,
    output logic       invalid
);
    // An invalid digit may overflow 10 bits; the result is flagged anyway,
    // so the wrap-around is harmless.
    assign value   = 10'(hund) * 10'd100 + 10'(tens) * 10'd10 + 10'(ones);
    assign invalid = (hund > 4'd9) || (tens > 4'd9) || (ones > 4'd9);
endmodule

// File: rtl/hex_display.sv
// -----------------------------------------------------------------------------
// hex_display
// Hex digit to active-low seven-segment decoder.
// Ports:
//   hex : 4-bit value
//   seg : segments {g,f,e,d,c,b,a}, 0 = lit
// -----------------------------------------------------------------------------
module hex_display (
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'b1111111;
        case (hex)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end
endmodule

// File: rtl/genbcd.sv
// -----------------------------------------------------------------------------
// genbcd
// Decimal-entry trainer: a binary target is shown on LEDR and the player keys
// its decimal value as three BCD digits on SW, submitting with KEY3.
// Optional build macro: GENBCD_HINT_EN (too-low / too-high hint on LEDG[4:3]).
// Ports:
//   clk50          : 50 MHz board clock
//   KEY2           : asynchronous active-low reset
//   KEY3           : raw active-low submit button
//   SW[11:0]       : hundreds/tens/ones digits; SW[17:12] unused
//   LEDR[7:0]      : current target
//   LEDG[7:0]      : [0] hit [1] invalid [2] miss [3] low [4] high [6] win [7] over
//   HEX0..HEX2     : entered ones/tens/hundreds digits
//   HEX6, HEX7     : score ones/tens digits
//   reset          : !KEY2
// -----------------------------------------------------------------------------
module genbcd
    import genbcd_pkg::*;
#(
    parameter logic [7:0] SEED         = 8'hB5,
    parameter int         ROUNDS       = 20,
    parameter int         MAX_STRIKES  = 3,
    parameter int         FLASH_CYCLES = 25_000_000
) (
    input  logic        clk50,
    input  logic        KEY2,
    input  logic        KEY3,
    input  logic [17:0] SW,
    output logic [7:0]  LEDR,
    output logic [7:0]  LEDG,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX6,
    output logic [6:0]  HEX7,
    output logic        reset
);
    localparam int               CNT_W        = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] FLASH_LOAD   = CNT_W'(FLASH_CYCLES - 1);
    localparam logic [3:0]       ROUNDS_ONES  = 4'(ROUNDS % 10);
    localparam logic [3:0]       ROUNDS_TENS  = 4'(ROUNDS / 10);
    localparam logic [3:0]       STRIKE_LIMIT = 4'(MAX_STRIKES);

    // ---------------- submit synchroniser and falling-edge detect ------------
    logic key3_meta_reg, key3_sync_reg, key3_prev_reg;
    logic submit_p;

    always_ff @(posedge clk50 or negedge KEY2) begin
        if (!KEY2) begin
            key3_meta_reg <= 1'b1;
            key3_sync_reg <= 1'b1;
            key3_prev_reg <= 1'b1;
        end else begin
            key3_meta_reg <= KEY3;
            key3_sync_reg <= key3_meta_reg;
            key3_prev_reg <= key3_sync_reg;
        end
    end

    // Acted on at the third clock edge after the pin falls.
    assign submit_p = key3_prev_reg & ~key3_sync_reg;

    // ---------------- entry decode ------------------------------------------
    logic [9:0] entry_value;
    logic       entry_invalid;
    logic       entry_correct;
    logic       sw_unused;

    bcd3_to_bin u_entry (
        .hund    (SW[11:8]),
        .tens    (SW[7:4]),
        .ones    (SW[3:0]),
        .value   (entry_value),
        .invalid (entry_invalid)
    );

    assign sw_unused = ^SW[17:12];

    // ---------------- game state --------------------------------------------
    state_t           state_reg;
    logic [7:0]       lfsr_reg;
    logic [3:0]       score_ones_reg, score_tens_reg;
    logic [3:0]       score_ones_next, score_tens_next;
    logic [3:0]       strikes_reg;
    logic [CNT_W-1:0] flash_cnt_reg;
    logic             score_done;

    assign entry_correct = !entry_invalid && (entry_value == {2'b00, lfsr_reg});
    assign score_done    = (score_ones_reg == ROUNDS_ONES) && (score_tens_reg == ROUNDS_TENS);

    // BCD increment saturating at 99.
    always_comb begin
        score_ones_next = score_ones_reg;
        score_tens_next = score_tens_reg;
        if (!(score_ones_reg == 4'd9 && score_tens_reg == 4'd9)) begin
            if (score_ones_reg == 4'd9) begin
                score_ones_next = 4'd0;
                score_tens_next = score_tens_reg + 4'd1;
            end else begin
                score_ones_next = score_ones_reg + 4'd1;
            end
        end
    end

    always_ff @(posedge clk50 or negedge KEY2) begin
        if (!KEY2) begin
            state_reg      <= S_PLAY;
            lfsr_reg       <= SEED;
            score_ones_reg <= 4'd0;
            score_tens_reg <= 4'd0;
            strikes_reg    <= 4'd0;
            flash_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                S_PLAY: begin
                    if (submit_p) begin
                        flash_cnt_reg <= FLASH_LOAD;
                        if (entry_correct) begin
                            lfsr_reg       <= lfsr_next(lfsr_reg);
                            score_ones_reg <= score_ones_next;
                            score_tens_reg <= score_tens_next;
                            state_reg      <= S_HIT;
                        end else begin
                            if (strikes_reg != 4'hF)
                                strikes_reg <= strikes_reg + 4'd1;
                            state_reg <= S_MISS;
                        end
                    end
                end
                S_HIT: begin
                    if (flash_cnt_reg == '0)
                        state_reg <= score_done ? S_OVER : S_PLAY;
                    else
                        flash_cnt_reg <= flash_cnt_reg - 1'b1;
                end
                S_MISS: begin
                    if (flash_cnt_reg == '0)
                        state_reg <= (strikes_reg == STRIKE_LIMIT) ? S_OVER : S_PLAY;
                    else
                        flash_cnt_reg <= flash_cnt_reg - 1'b1;
                end
                S_OVER: begin
                    state_reg <= S_OVER;
                end
                default: state_reg <= S_PLAY;
            endcase
        end
    end

    // ---------------- optional hint -----------------------------------------
    logic [1:0] hint_bits;  // {high, low}

`ifdef GENBCD_HINT_EN
    logic hint_low_reg, hint_high_reg;

    always_ff @(posedge clk50 or negedge KEY2) begin
        if (!KEY2) begin
            hint_low_reg  <= 1'b0;
            hint_high_reg <= 1'b0;
        end else if (state_reg == S_PLAY && submit_p && !entry_correct) begin
            // Invalid entries carry no meaningful magnitude.
            hint_low_reg  <= !entry_invalid && (entry_value < {2'b00, lfsr_reg});
            hint_high_reg <= !entry_invalid && (entry_value > {2'b00, lfsr_reg});
        end else if (state_reg == S_MISS && flash_cnt_reg == '0) begin
            hint_low_reg  <= 1'b0;
            hint_high_reg <= 1'b0;
        end
    end

    assign hint_bits = {hint_high_reg, hint_low_reg};
`else
    assign hint_bits = 2'b00;
`endif

    // ---------------- outputs -----------------------------------------------
    always_comb begin
        LEDG               = 8'h00;
        LEDG[LEDG_HIT]     = (state_reg == S_HIT);
        LEDG[LEDG_INVALID] = entry_invalid;
        LEDG[LEDG_MISS]    = (state_reg == S_MISS);
        LEDG[LEDG_LOW]     = hint_bits[0];
        LEDG[LEDG_HIGH]    = hint_bits[1];
        LEDG[LEDG_WIN]     = (state_reg == S_OVER) && score_done;
        LEDG[LEDG_OVER]    = (state_reg == S_OVER);
    end

    assign LEDR  = lfsr_reg;
    assign reset = !KEY2;

    // Display order: entered ones, tens, hundreds, then score ones, tens.
    logic [3:0] hex_digit [5];
    logic [6:0] hex_seg   [5];

    assign hex_digit[0] = SW[3:0];
    assign hex_digit[1] = SW[7:4];
    assign hex_digit[2] = SW[11:8];
    assign hex_digit[3] = score_ones_reg;
    assign hex_digit[4] = score_tens_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_hex
            hex_display u_hex (
                .hex (hex_digit[gi]),
                .seg (hex_seg[gi])
            );
        end
    endgenerate

    assign HEX0 = hex_seg[0];
    assign HEX1 = hex_seg[1];
    assign HEX2 = hex_seg[2];
    assign HEX6 = hex_seg[3];
    assign HEX7 = hex_seg[4];

endmodule

// File: tb/tb_genbcd.sv
// -----------------------------------------------------------------------------
// tb_genbcd
// Self-checking bench for genbcd (FLASH_CYCLES=4, ROUNDS=2, MAX_STRIKES=3).
// Each submit pushes its expected flash into a queue; a monitor pops and
// checks when a hit/miss flash starts, and times the flash length.
// -----------------------------------------------------------------------------
module tb_genbcd;

    logic        clk50 = 1'b0;
    logic        KEY2  = 1'b1;
    logic        KEY3  = 1'b1;
    logic [17:0] SW    = 18'h0;
    logic [7:0]  LEDR, LEDG;
    logic [6:0]  HEX0, HEX1, HEX2, HEX6, HEX7;
    logic        reset;

    always #5 clk50 = ~clk50;

    genbcd #(
        .SEED         (8'hB5),
        .ROUNDS       (2),
        .MAX_STRIKES  (3),
        .FLASH_CYCLES (4)
    ) dut (
        .clk50 (clk50),
        .KEY2  (KEY2),
        .KEY3  (KEY3),
        .SW    (SW),
        .LEDR  (LEDR),
        .LEDG  (LEDG),
        .HEX0  (HEX0),
        .HEX1  (HEX1),
        .HEX2  (HEX2),
        .HEX6  (HEX6),
        .HEX7  (HEX7),
        .reset (reset)
    );

`ifdef GENBCD_HINT_EN
    localparam bit HINT_ON = 1'b1;
`else
    localparam bit HINT_ON = 1'b0;
`endif

    typedef struct {
        logic       hit;
        logic [7:0] ledr;
        logic [3:0] ones;
        logic [3:0] tens;
        logic [1:0] hint;   // {high, low}
        int         start;
    } exp_t;

    exp_t sb_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   cyc       = 0;

    initial forever begin
        @(posedge clk50);
        cyc++;
    end

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            8:  return 7'b0000000;
            10: return 7'b0001000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Push the expected flash and press KEY3 for 'hold' cycles.
    task automatic press(input logic hit, input logic [7:0] ledr, input logic [3:0] ones,
                         input logic [3:0] tens, input logic [1:0] hint, input int hold,
                         input bit expect_flash);
        exp_t e;
        @(posedge clk50);
        #1;
        KEY3 = 1'b0;
        if (expect_flash) begin
            e.hit   = hit;
            e.ledr  = ledr;
            e.ones  = ones;
            e.tens  = tens;
            e.hint  = HINT_ON ? hint : 2'b00;
            e.start = cyc + 3;
            sb_q.push_back(e);
        end
        $display("submit SW=0x%03h hold=%0d expect=%s", SW[11:0], hold,
                 !expect_flash ? "none" : (hit ? "hit" : "miss"));
        repeat (hold) @(posedge clk50);
        #1;
        KEY3 = 1'b1;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk50);
        #1;
    endtask

    // ---------------- monitor ------------------------------------------------
    initial begin
        bit   in_flash = 1'b0;
        int   flen     = 0;
        exp_t e;
        forever begin
            @(negedge clk50);
            if (!KEY2) begin
                in_flash = 1'b0;
            end else if ((LEDG[0] | LEDG[2]) && !in_flash) begin
                in_flash = 1'b1;
                flen     = 1;
                if (sb_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_flash: got LEDG=0x%02h expected no flash (t=%0t)", LEDG, $time);
                end else begin
                    e = sb_q.pop_front();
                    $display("flash %s LEDR=0x%02h score=%0d%0d at cycle %0d",
                             LEDG[0] ? "hit" : "miss", LEDR, e.tens, e.ones, cyc);
                    check("flash_kind_hit",  32'(LEDG[0]), 32'(e.hit));
                    check("flash_kind_miss", 32'(LEDG[2]), 32'(!e.hit));
                    check("flash_start_cyc", 32'(cyc), 32'(e.start));
                    check("flash_ledr",      32'(LEDR), 32'(e.ledr));
                    check("flash_hex6",      32'(HEX6), 32'(seg_of(int'(e.ones))));
                    check("flash_hex7",      32'(HEX7), 32'(seg_of(int'(e.tens))));
                    check("flash_hint",      32'(LEDG[4:3]), 32'(e.hint));
                end
            end else if ((LEDG[0] | LEDG[2]) && in_flash) begin
                flen++;
            end else if (in_flash) begin
                in_flash = 1'b0;
                check("flash_length", 32'(flen), 32'd4);
            end
        end
    end

    // ---------------- stimulus -----------------------------------------------
    initial begin
        #2 KEY2 = 1'b0;
        #1;
        check("reset_out_asserted", 32'(reset), 32'd1);
        settle(3);
        KEY2 = 1'b1;
        #1;
        check("reset_ledr",   32'(LEDR), 32'hB5);
        check("reset_ledg",   32'(LEDG), 32'h00);
        check("reset_hex6",   32'(HEX6), 32'(seg_of(0)));
        check("reset_hex7",   32'(HEX7), 32'(seg_of(0)));
        check("reset_out",    32'(reset), 32'd0);
        settle(2);

        // Wrong by one, below target.
        SW = 18'h180;
        #1;
        check("hex0_180", 32'(HEX0), 32'(seg_of(0)));
        check("hex1_180", 32'(HEX1), 32'(seg_of(8)));
        check("hex2_180", 32'(HEX2), 32'(seg_of(1)));
        check("valid_180", 32'(LEDG[1]), 32'd0);
        press(1'b0, 8'hB5, 4'd0, 4'd0, 2'b01, 4, 1'b1);
        settle(15);
        check("after_miss_ledr", 32'(LEDR), 32'hB5);

        // Invalid tens digit.
        SW = 18'h1A1;
        #1;
        check("invalid_flag", 32'(LEDG[1]), 32'd1);
        check("hex1_A",       32'(HEX1), 32'(seg_of(10)));
        press(1'b0, 8'hB5, 4'd0, 4'd0, 2'b00, 4, 1'b1);
        settle(15);
        check("hint_cleared", 32'(LEDG[4:3]), 32'd0);

        // Correct answer held for 100 cycles: one pulse only.
        SW = 18'h181;
        press(1'b1, 8'h6B, 4'd1, 4'd0, 2'b00, 100, 1'b1);
        settle(15);
        check("score_after_hit", 32'(HEX6), 32'(seg_of(1)));

        // Second correct answer wins with ROUNDS=2.
        SW = 18'h107;
        press(1'b1, 8'hD6, 4'd2, 4'd0, 2'b00, 4, 1'b1);
        settle(15);
        check("win_ledg",  32'(LEDG), 32'hC0);
        check("win_hex6",  32'(HEX6), 32'(seg_of(2)));
        check("win_hex7",  32'(HEX7), 32'(seg_of(0)));
        press(1'b0, 8'h00, 4'd0, 4'd0, 2'b00, 4, 1'b0);
        settle(15);
        check("over_absorb_ledg", 32'(LEDG), 32'hC0);
        check("over_absorb_ledr", 32'(LEDR), 32'hD6);

        // Fresh game: three strikes.
        KEY2 = 1'b0;
        settle(2);
        KEY2 = 1'b1;
        SW   = 18'h000;
        settle(2);
        for (int i = 0; i < 3; i++) begin
            press(1'b0, 8'hB5, 4'd0, 4'd0, 2'b01, 4, 1'b1);
            settle(15);
        end
        check("lose_ledg", 32'(LEDG), 32'h80);
        press(1'b0, 8'h00, 4'd0, 4'd0, 2'b00, 4, 1'b0);
        settle(15);
        check("lose_absorb_ledg", 32'(LEDG), 32'h80);
        check("lose_absorb_ledr", 32'(LEDR), 32'hB5);

        // Reset in the middle of a hit flash.
        KEY2 = 1'b0;
        settle(2);
        KEY2 = 1'b1;
        SW   = 18'h181;
        settle(2);
        press(1'b1, 8'h6B, 4'd1, 4'd0, 2'b00, 4, 1'b1);
        check("midflash_in_hit", 32'(LEDG[0]), 32'd1);
        #2 KEY2 = 1'b0;
        #1;
        check("async_rst_ledr", 32'(LEDR), 32'hB5);
        check("async_rst_ledg", 32'(LEDG), 32'h00);
        check("async_rst_hex6", 32'(HEX6), 32'(seg_of(0)));
        check("async_rst_out",  32'(reset), 32'd1);
        settle(3);
        KEY2 = 1'b1;
        settle(10);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
